// File: rtl/lut_mux_prog.sv
// lut_mux_prog: serially loadable 2^SEL_W-entry lookup table with a registered valid/ready evaluation path.
// Define LUT_SHADOW_EN to stage loads in a shadow register and commit them atomically on the final bit.
module lut_mux_prog #(
   parameter int                    SEL_W = 3,
   parameter logic [(1<<SEL_W)-1:0] INIT  = 8'hC9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_busy,
   output logic             cfg_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel,
   output logic             out_valid,
   output logic             out
);
   localparam int N = 1 << SEL_W;
   localparam logic [SEL_W:0] LAST = (SEL_W+1)'(N - 1);
   typedef enum logic {IDLE, LOAD} state_t;
   state_t         state;
   logic [SEL_W:0] cnt;
   logic [N-1:0]   tbl, nxt;
   logic           last;
   assign last = cnt == LAST;
`ifdef LUT_SHADOW_EN
   logic [N-1:0] shadow;
   assign in_ready = 1'b1;
   always_comb begin
      nxt = shadow;
      nxt[cnt[SEL_W-1:0]] = cfg_bit;
   end
`else
   // Evaluation is blocked while the live table is being overwritten.
   assign in_ready = state == IDLE;
   always_comb begin
      nxt = tbl;
      nxt[cnt[SEL_W-1:0]] = cfg_bit;
   end
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         tbl       <= INIT;
`ifdef LUT_SHADOW_EN
         shadow    <= INIT;
`endif
         out       <= 1'b0;
         out_valid <= 1'b0;
         cfg_busy  <= 1'b0;
         cfg_done  <= 1'b0;
      end else begin
         out_valid <= in_valid & in_ready;
         if (in_valid & in_ready) out <= tbl[sel];
         cfg_done <= 1'b0;
         if (state == IDLE) begin
            if (cfg_start) begin
               state    <= LOAD;
               cnt      <= '0;
               cfg_busy <= 1'b1;
            end
         end else if (cfg_valid) begin
            cnt <= cnt + 1'b1;
`ifdef LUT_SHADOW_EN
            shadow <= nxt;
            if (last) tbl <= nxt;
`else
            tbl <= nxt;
`endif
            if (last) begin
               state    <= IDLE;
               cfg_busy <= 1'b0;
               cfg_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_lut_mux_prog.sv
// tb_lut_mux_prog: table-driven and scoreboarded bench for lut_mux_prog (default 8-entry, INIT 8'hC9).
module tb_lut_mux_prog;
   localparam int N = 8;
   localparam logic [7:0] INIT = 8'hC9;
   typedef struct {logic [2:0] sel; logic exp;} vec_t;
   logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0, in_valid = 1'b0;
   logic [2:0] sel = '0;
   logic cfg_busy, cfg_done, in_ready, out_valid, out;
   int nvec = 0, nerr = 0;
   bit mon_en = 1'b0;
   logic q[$];
   logic [7:0] mtbl = INIT;

   always #5 clk = ~clk;

   lut_mux_prog #(.SEL_W(3), .INIT(INIT)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .out_valid(out_valid), .out(out)
   );

   task automatic chkb(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: an entry pushed before an edge is the result due right after that edge.
   initial begin
      forever begin
         @(posedge clk);
         if (mon_en) begin : mon
            logic ev, eo;
            ev = q.size() > 0;
            eo = ev ? q.pop_front() : 1'b0;
            #1;
            chkb("out_valid", out_valid, ev);
            if (ev) chkb("out", out, eo);
         end
      end
   end

   task automatic ev(input logic [2:0] s, input logic e);
      in_valid = 1'b1;
      sel = s;
      q.push_back(e);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic evall;
      for (int s = 0; s < N; s++) ev(3'(s), mtbl[s]);
   endtask

   task automatic drive_ev(input bit evl);
      if (evl) begin
         in_valid = 1'b1;
         sel = 3'd0;
`ifdef LUT_SHADOW_EN
         q.push_back(mtbl[0]);
`else
         chkb("in_ready_load", in_ready, 1'b0);
`endif
      end
   endtask

   task automatic load(input logic [7:0] v, input int gap_at, input int gap_len, input int restart_at, input bit evl);
      int busy_n;
      busy_n = 0;
      in_valid = 1'b0;
      cfg_start = 1'b1;
      tick;
      cfg_start = 1'b0;
      busy_n += int'(cfg_busy);
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               cfg_valid = 1'b0;
               drive_ev(evl);
               tick;
               busy_n += int'(cfg_busy);
               chkb("cfg_done_gap", cfg_done, 1'b0);
            end
         end
         cfg_valid = 1'b1;
         cfg_bit = v[i];
         cfg_start = (i == restart_at);
         drive_ev(evl);
         tick;
         cfg_start = 1'b0;
         busy_n += int'(cfg_busy);
         chkb("cfg_done_bit", cfg_done, i == N - 1);
      end
      cfg_valid = 1'b0;
      in_valid = 1'b0;
      mtbl = v;
      chki("cfg_busy_cycles", busy_n, 8 + gap_len);
      tick;
      chkb("cfg_done_width", cfg_done, 1'b0);
      chkb("cfg_busy_idle", cfg_busy, 1'b0);
   endtask

   initial begin
      vec_t v1[8];
      vec_t v2[3];
      v1 = '{'{3'd0, 1'b1}, '{3'd1, 1'b0}, '{3'd2, 1'b0}, '{3'd3, 1'b1},
             '{3'd4, 1'b0}, '{3'd5, 1'b0}, '{3'd6, 1'b1}, '{3'd7, 1'b1}};
      v2 = '{'{3'd0, 1'b0}, '{3'd1, 1'b1}, '{3'd7, 1'b1}};
      tick;
      tick;
      rst_n = 1'b1;
      mon_en = 1'b1;
      chkb("rst_out", out, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_cfg_busy", cfg_busy, 1'b0);
      chkb("rst_cfg_done", cfg_done, 1'b0);
      chkb("rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 8; i++) ev(v1[i].sel, v1[i].exp);
      tick;
      load(8'h96, -1, 0, -1, 1'b0);
      for (int i = 0; i < 3; i++) ev(v2[i].sel, v2[i].exp);
      load(8'hFF, 4, 3, -1, 1'b0);
      evall;
      in_valid = 1'b0;
      cfg_start = 1'b1;
      tick;
      cfg_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1;
         cfg_bit = 1'b0;
         tick;
         chkb("busy_partial", cfg_busy, 1'b1);
      end
      rst_n = 1'b0;
      tick;
      chkb("busy_after_rst", cfg_busy, 1'b0);
      chkb("done_after_rst", cfg_done, 1'b0);
      rst_n = 1'b1;
      cfg_valid = 1'b0;
      mtbl = INIT;
      tick;
      chkb("done_post_rst", cfg_done, 1'b0);
      chkb("busy_post_rst", cfg_busy, 1'b0);
      ev(3'd0, 1'b1);
      ev(3'd3, 1'b1);
      ev(3'd4, 1'b0);
      load(8'hA5, -1, 0, 3, 1'b0);
      evall;
      load(8'h00, -1, 0, -1, 1'b1);
      ev(3'd0, 1'b0);
      evall;
      tick;
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
